clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Runtime-programmable clock-enable/clock divider. Successor to the fixed
//  divide-by-1000 toggle divider. Full period N is loaded at run time,
//  including odd N. Divisor changes are glitch-free, taking effect only at a
//  period boundary. Stop is graceful: the current period completes first.
//  Emits a near-50% divided clock level plus a one-cycle tick per period.
//  Feeds display scan, debounce and seconds counters in the same fabric.
// PARAMETERS
//  CNT_W       16    width of divisor and period counter
//  DEF_DIV     1000  divisor after reset; 2 <= DEF_DIV <= 2^CNT_W-1
//  IDLE_LEVEL  1'b1  clk_out level while stopped and in reset
// PORTS
//  clk      in   1      system clock
//  rstn     in   1      asynchronous active-low reset
//  en       in   1      run request, level-sensitive
//  div_wr   in   1      one-cycle divisor write strobe
//  div_in   in   CNT_W  requested full period N, in clk cycles
//  div_busy out  1      a write is pending, not yet applied
//  div_err  out  1      1-cycle pulse: write rejected (div_in < 2)
//  div_cur  out  CNT_W  divisor currently in force
//  clk_out  out  1      divided clock level
//  tick     out  1      high in the last cycle of every period
//  running  out  1      FSM is not in STOP
// BEHAVIOUR
//  Reset (async, rstn=0): state=STOP, cnt=0, div_cur=DEF_DIV, pending cleared.
//   Outputs: div_busy=0, div_err=0, tick=0, running=0, clk_out=IDLE_LEVEL.
//  All outputs are registered. No combinational path from inputs to outputs.
//  Period (N=div_cur): cnt runs 0..N-1, then wraps to 0.
//   In the cycle where cnt==k: clk_out = (k < ceil(N/2)) and tick = (k==N-1).
//   Example, N=5: 3 cycles high, 2 low.
//  FSM states:
//   STOP:  cnt=0, clk_out=IDLE_LEVEL. If en=1, go to RUN.
//          The first RUN cycle has cnt=0 and clk_out=1.
//   RUN:   counts. If en=0, go to DRAIN; counting continues uninterrupted.
//   DRAIN: counts. If en=1, return to RUN with no phase disturbance.
//          At the wrap edge (cnt==N-1), go to STOP.
//          The tick of the final period is still issued.
//  Divisor write (sampled on an edge where div_wr=1):
//   div_in < 2: no change at all; div_err=1 for the next cycle only.
//   In STOP: div_cur<=div_in on that edge, and div_busy stays 0.
//   Otherwise: captured into pending, and div_busy=1 from the next cycle.
//    Pending is applied on the first wrap edge where it was already valid
//    before that edge. div_cur updates, cnt restarts at 0 under the new N,
//    and div_busy clears on the same edge.
//    A write sampled on the wrap edge itself applies one period later.
//   A second write while pending overwrites pending. Last write wins.
//   Pending apply in DRAIN->STOP: the new value is applied on that edge.
//  Wrap-around: cnt never exceeds N-1. Compare width is CNT_W; no overflow.
//  rstn low mid-period: outputs and state return to reset values
//   immediately; a pending write is discarded.
// TESTING
//  1 Reset, en=1, N=1000 -> clk_out 500 high/500 low; tick every 1000th cycle; running=1
//  2 STOP, write 5 then en=1 -> div_cur=5 next cycle; 3 high/2 low; tick period 5
//  3 N=10, write 8 at cnt=3 -> busy 7 cycles; 10-cycle period ends; then 4/4, busy=0
//  4 write div_in=0 and div_in=1 -> div_err 1-cycle pulse each; div_cur, busy unchanged
//  5 N=10, en low at cnt=3 -> period finishes, tick at cnt=9, then clk_out=1, running=0;
//    repeat with en high at cnt=6 -> no gap, continuous periods
//  6 rstn low at cnt=4 with write pending -> immediate reset outputs; div_cur=1000; busy=0

Source files
------------

// File: rtl/clk_div_prog_if.sv
// Control/status bundle for the programmable clock divider.
interface clk_div_prog_if #(
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic             div_wr;
  logic [CNT_W-1:0] div_in;
  logic             div_busy;
  logic             div_err;
  logic [CNT_W-1:0] div_cur;
  logic             clk_out;
  logic             tick;
  logic             running;

  modport master (
    output en, div_wr, div_in,
    input  div_busy, div_err, div_cur, clk_out, tick, running
  );

  modport slave (
    input  en, div_wr, div_in,
    output div_busy, div_err, div_cur, clk_out, tick, running
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: near-50% divided level plus a one-cycle
// tick per period, glitch-free divisor changes at period boundaries and a
// graceful stop that finishes the period in progress.
module clk_div_prog #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DEF_DIV    = 1000,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  clk_div_prog_if.slave bus
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_vld_q, pend_vld_d;
  logic             err_q, err_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;

  logic             wrap_c;
  logic             in_ok_c;
  logic             boundary_c;
  logic [CNT_W-1:0] half_c;

  assign wrap_c     = (cnt_q == (div_cur_q - CNT_W'(1)));
  assign in_ok_c    = (bus.div_in >= CNT_W'(2));
  assign boundary_c = (state_q == ST_STOP) || wrap_c;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_STOP;
    else       state_q <= state_d;
  end

  // Next-state logic: DRAIN keeps counting and only stops at the wrap edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP:  if (bus.en) state_d = ST_RUN;
      ST_RUN:   if (!bus.en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.en)      state_d = ST_RUN;
        else if (wrap_c) state_d = ST_STOP;
      end
      default:  state_d = ST_STOP;
    endcase
  end

  // Counter and divisor update; a write on the apply edge re-arms pending
  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    pend_val_d = pend_val_q;
    pend_vld_d = pend_vld_q;
    err_d      = bus.div_wr && !in_ok_c;

    if (state_q != ST_STOP) begin
      cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
    end

    if (boundary_c && pend_vld_q) begin
      div_cur_d  = pend_val_q;
      pend_vld_d = 1'b0;
    end

    if (bus.div_wr && in_ok_c) begin
      if (state_q == ST_STOP) begin
        div_cur_d = bus.div_in;
      end else begin
        pend_val_d = bus.div_in;
        pend_vld_d = 1'b1;
      end
    end

    if (state_d == ST_STOP) cnt_d = '0;
  end

  // Output decode from next-cycle values so the flopped outputs line up with cnt
  always_comb begin
    half_c    = (div_cur_d >> 1) + CNT_W'(div_cur_d[0]);
    running_d = (state_d != ST_STOP);
    clk_out_d = running_d ? (cnt_d < half_c) : IDLE_LEVEL;
    tick_d    = running_d && (cnt_d == (div_cur_d - CNT_W'(1)));
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      div_cur_q  <= CNT_W'(DEF_DIV);
      pend_val_q <= '0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
      clk_out_q  <= IDLE_LEVEL;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_val_q <= pend_val_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      running_q  <= running_d;
    end
  end

  assign bus.div_busy = pend_vld_q;
  assign bus.div_err  = err_q;
  assign bus.div_cur  = div_cur_q;
  assign bus.clk_out  = clk_out_q;
  assign bus.tick     = tick_q;
  assign bus.running  = running_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: vector table for STOP-state writes, error
// pulses and a short drain, then hand sequences for multi-cycle cases.
module tb_clk_div_prog;

  logic clk;
  logic rstn;
  int   n_tests;
  int   n_fail;

  clk_div_prog_if #(.CNT_W(16)) bus ();

  clk_div_prog #(
    .CNT_W(16),
    .DEF_DIV(1000),
    .IDLE_LEVEL(1'b1)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit en;
    bit wr;
    int din;
    bit co;
    bit tk;
    bit rn;
    bit by;
    bit er;
    int cur;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit co, input bit tk,
                           input bit rn, input bit by, input bit er,
                           input int cur);
    chk({tag, ".clk_out"},  int'(bus.clk_out),  int'(co));
    chk({tag, ".tick"},     int'(bus.tick),     int'(tk));
    chk({tag, ".running"},  int'(bus.running),  int'(rn));
    chk({tag, ".div_busy"}, int'(bus.div_busy), int'(by));
    chk({tag, ".div_err"},  int'(bus.div_err),  int'(er));
    chk({tag, ".div_cur"},  int'(bus.div_cur),  cur);
  endtask

  task automatic drive(input bit e, input bit w, input int d);
    bus.en     = e;
    bus.div_wr = w;
    bus.div_in = 16'(d);
  endtask

  // One clock, then settle past the edge before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One running cycle expected at count k of an n-cycle period
  task automatic run_k(input string tag, input int k, input int n,
                       input bit by, input int cur);
    step();
    check_out($sformatf("%s.k%0d", tag, k), k < (n + 1) / 2, k == n - 1,
              1'b1, by, 1'b0, cur);
  endtask

  task automatic stop_chk(input string tag, input int cur);
    step();
    check_out(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, cur);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rstn    = 1'b0;
    drive(0, 0, 0);

    //                en wr din  co tk rn by er cur
    vecs[0]  = '{1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5};
    vecs[1]  = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5};
    vecs[2]  = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5};
    vecs[3]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5};
    vecs[4]  = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    vecs[5]  = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    vecs[6]  = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    vecs[7]  = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    vecs[8]  = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5};
    vecs[9]  = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    vecs[10] = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5};
    vecs[11] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    vecs[12] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    vecs[13] = '{1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5};
    vecs[14] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5};
    vecs[15] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1000);
    @(negedge clk);
    rstn = 1'b1;
    stop_chk("post_reset", 1000);

    // STOP-state write, rejected writes, N=5 period and a short drain
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].en, vecs[i].wr, vecs[i].din);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].co, vecs[i].tk, vecs[i].rn,
                vecs[i].by, vecs[i].er, vecs[i].cur);
    end

    // N=10, write 8 landing in the cnt=3 cycle: busy for cnt 3..9, then 4/4
    drive(0, 1, 10);
    stop_chk("t3.load", 10);
    drive(1, 0, 0);
    for (int k = 0; k < 3; k++) run_k("t3.a", k, 10, 1'b0, 10);
    drive(1, 1, 8);
    run_k("t3.a", 3, 10, 1'b1, 10);
    drive(1, 0, 0);
    for (int k = 4; k < 10; k++) run_k("t3.a", k, 10, 1'b1, 10);
    for (int i = 0; i < 16; i++) run_k("t3.b", i % 8, 8, 1'b0, 8);
    drive(0, 0, 0);
    for (int k = 0; k < 8; k++) run_k("t3.c", k, 8, 1'b0, 8);
    stop_chk("t3.stop", 8);

    // Graceful stop with en dropped at cnt=3
    drive(0, 1, 10);
    stop_chk("t5.load", 10);
    drive(1, 0, 0);
    for (int k = 0; k < 4; k++) run_k("t5.a", k, 10, 1'b0, 10);
    drive(0, 0, 0);
    for (int k = 4; k < 10; k++) run_k("t5.a", k, 10, 1'b0, 10);
    stop_chk("t5.stop0", 10);
    stop_chk("t5.stop1", 10);

    // Drain cancelled at cnt=6: periods continue without a gap
    drive(1, 0, 0);
    for (int k = 0; k < 4; k++) run_k("t5.b", k, 10, 1'b0, 10);
    drive(0, 0, 0);
    for (int k = 4; k < 6; k++) run_k("t5.b", k, 10, 1'b0, 10);
    drive(1, 0, 0);
    for (int k = 6; k < 10; k++) run_k("t5.b", k, 10, 1'b0, 10);
    for (int k = 0; k < 10; k++) run_k("t5.c", k, 10, 1'b0, 10);

    // Two writes in one period: the later one is applied at the wrap
    drive(1, 1, 6);
    run_k("lww", 0, 10, 1'b1, 10);
    drive(1, 1, 7);
    run_k("lww", 1, 10, 1'b1, 10);
    drive(1, 0, 0);
    for (int k = 2; k < 10; k++) run_k("lww", k, 10, 1'b1, 10);
    for (int k = 0; k < 2; k++) run_k("n7", k, 7, 1'b0, 7);

    // Pending write applied on the DRAIN->STOP edge
    drive(0, 1, 4);
    run_k("n7", 2, 7, 1'b1, 7);
    drive(0, 0, 0);
    for (int k = 3; k < 7; k++) run_k("n7", k, 7, 1'b1, 7);
    stop_chk("drain_apply", 4);

    // Async reset at cnt=4 with a write pending
    drive(0, 1, 10);
    stop_chk("t6.load", 10);
    drive(1, 0, 0);
    for (int k = 0; k < 4; k++) run_k("t6", k, 10, 1'b0, 10);
    drive(1, 1, 3);
    run_k("t6", 4, 10, 1'b1, 10);
    drive(1, 0, 0);
    #2;
    rstn = 1'b0;
    #1;
    check_out("t6.rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1000);
    @(negedge clk);
    drive(0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    stop_chk("t6.after0", 1000);
    stop_chk("t6.after1", 1000);

    // Default divisor: 500 high / 500 low, tick every 1000th cycle
    drive(1, 0, 0);
    for (int i = 0; i < 2000; i++) run_k("t1", i % 1000, 1000, 1'b0, 1000);
    drive(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
